// File: rtl/aes_gf_defs.sv
// Shared GF(2^8) definitions for the AES MixColumns datapath: reduction
// constant, mode encodings, engine states, byte-slice positions and xtime.
package aes_gf_defs;

   localparam logic [7:0] AES_POLY_LOW = 8'h1B;

   localparam logic MODE_MIX    = 1'b0;
   localparam logic MODE_INVMIX = 1'b1;

   localparam int COL_W  = 32;
   localparam int BYTE_W = 8;

   // Row r of a column sits at [31-8r -: 8]; row 0 is the most significant byte.
   localparam int ROW0_MSB = 31;
   localparam int ROW1_MSB = 23;
   localparam int ROW2_MSB = 15;
   localparam int ROW3_MSB = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } eng_state_e;

   // Multiply by x in GF(2^8): shift left, reduce by 0x11B when the top bit falls out.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_LOW : 8'h00);
   endfunction

endpackage

// File: rtl/gf_column_mix.sv
// Combinational AES column mixer: one 32-bit column through the forward
// {02,03,01,01} or inverse {0e,0b,0d,09} circulant matrix, built from xtime chains.
module gf_column_mix
   import aes_gf_defs::*;
(
   input  logic [COL_W-1:0] col_i,
   input  logic             mode_i,
   output logic [COL_W-1:0] col_o
);

   logic [BYTE_W-1:0] a0, a1, a2, a3;

   // One output row: b0 is the byte on the matrix diagonal, b1..b3 follow it cyclically.
   function automatic logic [7:0] mix_row(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3,
                                          input logic inv);
      logic [7:0] b0x2, b0x4, b0x8, b1x2, b1x4, b1x8;
      logic [7:0] b2x2, b2x4, b2x8, b3x2, b3x4, b3x8;
      b0x2 = xtime(b0); b0x4 = xtime(b0x2); b0x8 = xtime(b0x4);
      b1x2 = xtime(b1); b1x4 = xtime(b1x2); b1x8 = xtime(b1x4);
      b2x2 = xtime(b2); b2x4 = xtime(b2x2); b2x8 = xtime(b2x4);
      b3x2 = xtime(b3); b3x4 = xtime(b3x2); b3x8 = xtime(b3x4);
      if (inv == MODE_INVMIX)
         mix_row = (b0x8 ^ b0x4 ^ b0x2) ^ (b1x8 ^ b1x2 ^ b1) ^ (b2x8 ^ b2x4 ^ b2) ^ (b3x8 ^ b3);
      else
         mix_row = b0x2 ^ (b1x2 ^ b1) ^ b2 ^ b3;
   endfunction

   assign a0 = col_i[ROW0_MSB -: BYTE_W];
   assign a1 = col_i[ROW1_MSB -: BYTE_W];
   assign a2 = col_i[ROW2_MSB -: BYTE_W];
   assign a3 = col_i[ROW3_MSB -: BYTE_W];

   // Each output row uses the same coefficient row rotated by its row index.
   always_comb begin
      col_o = '0;
      col_o[ROW0_MSB -: BYTE_W] = mix_row(a0, a1, a2, a3, mode_i);
      col_o[ROW1_MSB -: BYTE_W] = mix_row(a1, a2, a3, a0, mode_i);
      col_o[ROW2_MSB -: BYTE_W] = mix_row(a2, a3, a0, a1, mode_i);
      col_o[ROW3_MSB -: BYTE_W] = mix_row(a3, a0, a1, a2, mode_i);
   end

endmodule

// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns/InvMixColumns engine: accepts a full state,
// mixes one column per clock through a shared column mixer, then holds the
// result until the downstream takes it.
module mix_columns_engine
   import aes_gf_defs::*;
#(
   parameter int NUM_COLUMNS = 4,
   parameter int STATE_W     = 32 * NUM_COLUMNS
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [STATE_W-1:0] inState,
   input  logic               inMode,
   input  logic               inValid,
   output logic               inReady,
   output logic [STATE_W-1:0] outState,
   output logic               outValid,
   input  logic               outReady
);

   localparam int CNT_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLUMNS - 1);

   eng_state_e         state_q;
   logic [STATE_W-1:0] work_q, work_d;
   logic [CNT_W-1:0]   col_cnt_q;
   logic               mode_q;
   logic               out_valid_q;
   logic [COL_W-1:0]   col_sel, col_mixed;

   // Pick the column currently being processed; column 0 is the top 32 bits.
   always_comb begin
      col_sel = '0;
      for (int c = 0; c < NUM_COLUMNS; c++) begin
         if (col_cnt_q == CNT_W'(c))
            col_sel = work_q[STATE_W-1-COL_W*c -: COL_W];
      end
   end

   gf_column_mix u_mix (
      .col_i  (col_sel),
      .mode_i (mode_q),
      .col_o  (col_mixed)
   );

   // Write the mixed column back in place, leaving the other columns untouched.
   always_comb begin
      work_d = work_q;
      for (int c = 0; c < NUM_COLUMNS; c++) begin
         if (col_cnt_q == CNT_W'(c))
            work_d[STATE_W-1-COL_W*c -: COL_W] = col_mixed;
      end
   end

   // Control FSM with working register, column counter and latched mode.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         work_q      <= '0;
         col_cnt_q   <= '0;
         mode_q      <= MODE_MIX;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (inValid) begin
                  work_q    <= inState;
                  mode_q    <= inMode;
                  col_cnt_q <= '0;
                  state_q   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               work_q <= work_d;
               if (col_cnt_q == LAST_COL) begin
                  col_cnt_q   <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  col_cnt_q <= col_cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (outReady) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Only a finished block is ever visible on outState.
   assign inReady  = (state_q == ST_IDLE);
   assign outValid = out_valid_q;
   assign outState = out_valid_q ? work_q : '0;

endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Sequential AES MixColumns / InvMixColumns engine for a full cipher state. It takes an `NUM_COLUMNS`-column state through a valid/ready handshake and transforms one 32-bit column per clock. Each column uses a shared GF(2^8) column mixer, and the mode (forward or inverse) is selected per block. It sits between ShiftRows and AddRoundKey in the round datapath and supersedes the single-byte GF multiply stage.

## Interface
- `NUM_COLUMNS`, default 4: number of 32-bit state columns (Nb). Legal range is 1..8, so Rijndael 256-bit blocks use 8.
- `STATE_W`, default 32*`NUM_COLUMNS`: state width. It is derived and must not be overridden.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: reset is asynchronous and active-high.
- `inState` input `STATE_W`: state to transform.
  - Column 0 occupies `[STATE_W-1 -: 32]`.
  - Within a column, row 0 is bits `[31:24]`.
- `inMode` input 1: 0 = MixColumns, 1 = InvMixColumns.
- `inValid` input 1: `inState`/`inMode` are valid.
- `inReady` output 1: the engine can accept a block.
- `outState` output `STATE_W`: transformed state, same byte ordering as `inState`.
- `outValid` output 1: `outState` is valid.
- `outReady` input 1: downstream accepts `outState`.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - `inReady`=1.
  - On `inValid`&`inReady`: latch `inState` into the working register, latch `inMode`, clear `colCount` to 0, go to BUSY.
- **BUSY**
  - `inReady`=0.
  - Each cycle, column `colCount` of the working register passes through the column mixer, and the result is written back in place.
  - `colCount` increments each cycle.
  - When `colCount`==`NUM_COLUMNS`-1 is processed, go to DONE.
- **DONE**
  - `outValid`=1 and `outState` = working register.
  - Both are held stable until `outReady`=1.
  - On `outValid`&`outReady`, go to IDLE.
- Forward matrix rows: {02,03,01,01} rotated per row.
- Inverse matrix rows: {0e,0b,0d,09} rotated per row.
- GF(2^8) arithmetic:
  - Reduction polynomial is x^8+x^4+x^3+x+1 (0x11B). `xtime` is a left shift, XORed with 0x1B when bit 7 was set.
  - Products are composed from `xtime` chains and XOR; no multipliers and no lookup tables.
  - All intermediate values are 8 bits, and the reduction is applied after every shift.
- Mode is sampled only at acceptance. Changes on `inMode` during BUSY/DONE have no effect.
- `inValid` while not ready is ignored; the upstream holds its data.
- `outReady` high before DONE has no effect.
- `NUM_COLUMNS`=1:
  - BUSY lasts exactly one cycle.
  - `colCount` is 1 bit wide minimum, and the wrap compare still applies.

## Timing
- Reset values: state IDLE, `inReady`=1 (combinational from IDLE), `outValid`=0, `outState`=0, `colCount`=0, latched mode=0.
- Block accepted at edge N:
  - BUSY covers edges N+1..N+`NUM_COLUMNS`.
  - `outValid` rises after edge N+`NUM_COLUMNS`.
- Minimum initiation interval is `NUM_COLUMNS`+2 cycles: accept, `NUM_COLUMNS` busy cycles, one DONE cycle with `outReady`=1.
- There is no new acceptance in the DONE→IDLE transition cycle. `inReady` rises the cycle after the output handshake.
- Reset asserted mid-BUSY or mid-DONE:
  - Immediately abandons the block and returns all outputs to reset values.
  - No partial result is ever presented.
- The column mixer is purely combinational and must meet a single cycle.

## Structure
- Shared package/header `aes_gf_defs` holds:
  - `AES_POLY_LOW` = 8'h1B.
  - Mode encodings `MODE_MIX`=0 and `MODE_INVMIX`=1.
  - The `xtime` function.
  - Column/row byte-slice index constants.
- Sub-module `gf_column_mix`:
  - Combinational; ports are 32-bit column in, mode in, 32-bit column out.
  - Instantiated once and time-multiplexed across columns.
  - Unit-testable in isolation.
- Top holds the FSM, `colCount`, the working register and the handshake logic.

## Test plan
- **Forward, single column.** Forward, `NUM_COLUMNS`=4, every column = db135345 → every output column = 8e4da1bc. `outValid` appears exactly 4 cycles after acceptance.
- **Inverse and invariants.** Inverse with columns {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6} → {db135345, f20a225c, 01010101, c6c6c6c6}.
- **Round trip.** Forward then inverse of a random state returns the original for 1000 random states and both `NUM_COLUMNS`=4 and 8.
- **Backpressure.** `outReady` held low 10 cycles after `outValid`. Required:
  - `outState` stays stable.
  - `inReady` stays 0 and a second `inValid` is ignored.
  - After `outReady`, the next block is accepted one cycle later.
- **Mode sampling and reset.** Change `inMode` during BUSY → result follows the latched mode. Assert `reset` during BUSY → `outValid`=0 and `outState`=0 immediately, `inReady`=1, and the next block processes correctly.
- **Minimum width.** `NUM_COLUMNS`=1, column d4d4d4d5 forward → d5d5d7d6 with latency 1.
